// File: rtl/quad_solver_seq.sv
// quad_solver_seq: multi-cycle solver for a*x^2 + b*x + c = 0 with signed
// 4-bit coefficients. One cycle computes the discriminant, five cycles
// extract its integer square root bit-serially, and a single restoring
// divider is reused twice to produce x1 and then x2.
//
// Handshake: start is sampled only in IDLE or DONE; on that edge the
// coefficients are latched and busy rises. busy stays high through
// CALC/SQRT/DIV1/DIV2. done is a one-cycle pulse in DONE, and x1/x2/status
// are valid from that cycle until the next accepted start. start while busy
// is ignored.
module quad_solver_seq (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic signed [3:0] a,
    input  logic signed [3:0] b,
    input  logic signed [3:0] c,
    output logic              busy,
    output logic              done,
    output logic [1:0]        status,
    output logic signed [7:0] x1,
    output logic signed [7:0] x2,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CALC = 3'd1,
        S_SQRT = 3'd2,
        S_DIV1 = 3'd3,
        S_DIV2 = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t            state;
    logic signed [3:0] a_r, b_r, c_r;
    logic signed [9:0] delta_r;
    logic [4:0]        root;
    logic [2:0]        bit_idx;
    logic [5:0]        div_num;
    logic [4:0]        div_rem;
    logic [5:0]        div_quo;
    logic              div_neg;

    assign state_dbg = state;

    // Discriminant in 10-bit signed arithmetic; range -256..288 never overflows.
    logic signed [9:0] a_ext, b_ext, c_ext, delta_calc;
    assign a_ext      = {{6{a_r[3]}}, a_r};
    assign b_ext      = {{6{b_r[3]}}, b_r};
    assign c_ext      = {{6{c_r[3]}}, c_r};
    assign delta_calc = b_ext * b_ext - 10'sd4 * a_ext * c_ext;

    // One square-root bit trial: keep the bit if trial^2 still fits in delta.
    logic [4:0]  trial;
    logic [10:0] trial_w, trial_sq;
    logic [4:0]  root_next;
    assign trial     = root | (5'd1 << bit_idx);
    assign trial_w   = {6'b0, trial};
    assign trial_sq  = trial_w * trial_w;
    assign root_next = (trial_sq <= {1'b0, delta_r}) ? trial : root;

    // Divider operands. On the last SQRT cycle the root is still in flight,
    // so the first numerator uses root_next; the second uses the settled root.
    logic [4:0]        s_sel;
    logic signed [6:0] b7, s7, num_sel;
    logic [5:0]        num_mag;
    logic [3:0]        a_mag;
    logic [4:0]        den_mag;
    assign s_sel   = (state == S_SQRT) ? root_next : root;
    assign b7      = {{3{b_r[3]}}, b_r};
    assign s7      = {2'b0, s_sel};
    assign num_sel = (state == S_SQRT) ? (s7 - b7) : (-b7 - s7);
    assign num_mag = num_sel[6] ? 6'(-num_sel) : num_sel[5:0];
    assign a_mag   = a_r[3] ? 4'(-a_r) : a_r;
    assign den_mag = {a_mag, 1'b0};

    // One restoring-division step: shift in the next numerator bit, subtract
    // the denominator when it fits. Remainder stays below 16, so 5 bits hold it.
    logic [5:0] rem_shift, rem_sub;
    logic       rem_ge;
    logic [5:0] quo_next;
    logic [7:0] quo_ext, div_result;
    assign rem_shift  = {div_rem, div_num[5]};
    assign rem_ge     = rem_shift >= {1'b0, den_mag};
    assign rem_sub    = rem_shift - {1'b0, den_mag};
    assign quo_next   = {div_quo[4:0], rem_ge};
    assign quo_ext    = {2'b0, quo_next};
    assign div_result = div_neg ? (8'd0 - quo_ext) : quo_ext;

    // Sequencer: state, datapath registers and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            status  <= 2'b00;
            x1      <= 8'sd0;
            x2      <= 8'sd0;
            a_r     <= 4'sd0;
            b_r     <= 4'sd0;
            c_r     <= 4'sd0;
            delta_r <= 10'sd0;
            root    <= 5'd0;
            bit_idx <= 3'd0;
            div_num <= 6'd0;
            div_rem <= 5'd0;
            div_quo <= 6'd0;
            div_neg <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r    <= a;
                        b_r    <= b;
                        c_r    <= c;
                        x1     <= 8'sd0;
                        x2     <= 8'sd0;
                        status <= 2'b00;
                        busy   <= 1'b1;
                        state  <= S_CALC;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    delta_r <= delta_calc;
                    if (a_r == 4'sd0) begin
                        status <= 2'b10;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else if (delta_calc[9]) begin
                        status <= 2'b01;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        root    <= 5'd0;
                        bit_idx <= 3'd4;
                        state   <= S_SQRT;
                    end
                end
                S_SQRT: begin
                    root <= root_next;
                    if (bit_idx == 3'd0) begin
                        div_num <= num_mag;
                        div_rem <= 5'd0;
                        div_quo <= 6'd0;
                        div_neg <= num_sel[6] ^ a_r[3];
                        bit_idx <= 3'd5;
                        state   <= S_DIV1;
                    end else begin
                        bit_idx <= bit_idx - 3'd1;
                    end
                end
                S_DIV1: begin
                    div_num <= {div_num[4:0], 1'b0};
                    div_rem <= rem_ge ? rem_sub[4:0] : rem_shift[4:0];
                    div_quo <= quo_next;
                    if (bit_idx == 3'd0) begin
                        x1      <= div_result;
                        div_num <= num_mag;
                        div_rem <= 5'd0;
                        div_quo <= 6'd0;
                        div_neg <= num_sel[6] ^ a_r[3];
                        bit_idx <= 3'd5;
                        state   <= S_DIV2;
                    end else begin
                        bit_idx <= bit_idx - 3'd1;
                    end
                end
                S_DIV2: begin
                    div_num <= {div_num[4:0], 1'b0};
                    div_rem <= rem_ge ? rem_sub[4:0] : rem_shift[4:0];
                    div_quo <= quo_next;
                    if (bit_idx == 3'd0) begin
                        x2    <= div_result;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        bit_idx <= bit_idx - 3'd1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quad_solver_seq.sv
// Testbench for quad_solver_seq: directed cases from the solver's corner
// behaviour plus randomized coefficients, scored against an integer-arithmetic
// reference model through an expected-result queue.
module tb_quad_solver_seq;

    logic              clk;
    logic              rst;
    logic              start;
    logic signed [3:0] a, b, c;
    logic              busy, done;
    logic [1:0]        status;
    logic signed [7:0] x1, x2;
    logic [2:0]        state_dbg;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [17:0] exp_q[$];   // {status, x1, x2}
    int          lat_q[$];   // cycle count at the accepting edge

    quad_solver_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .c         (c),
        .busy      (busy),
        .done      (done),
        .status    (status),
        .x1        (x1),
        .x2        (x2),
        .state_dbg (state_dbg)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain integer math straight from the equation.
    function automatic logic [17:0] model(input int ai, input int bi, input int ci);
        int d, s, r1, r2;
        logic [1:0] st;
        d  = bi * bi - 4 * ai * ci;
        r1 = 0;
        r2 = 0;
        if (ai == 0) st = 2'b10;
        else if (d < 0) st = 2'b01;
        else begin
            st = 2'b00;
            s  = 0;
            while ((s + 1) * (s + 1) <= d) s++;
            r1 = (-bi + s) / (2 * ai);
            r2 = (-bi - s) / (2 * ai);
        end
        return {st, 8'(r1), 8'(r2)};
    endfunction

    // Monitor: every done pulse pops one expectation.
    always @(negedge clk) begin
        logic [17:0] e;
        int          l;
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: done=1 with no run outstanding (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                l = lat_q.pop_front();
                check("status", status, e[17:16]);
                check("x1", x1, $signed(e[15:8]));
                check("x2", x2, $signed(e[7:0]));
                check("latency", cyc - l, (e[17:16] == 2'b00) ? 18 : 1);
                check("busy_in_done", busy, 0);
            end
        end
    end

    // Driver: called at a negedge with the DUT in IDLE or DONE.
    task automatic issue(input logic signed [3:0] ai, input logic signed [3:0] bi,
                         input logic signed [3:0] ci);
        a = ai; b = bi; c = ci; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        exp_q.push_back(model(ai, bi, ci));
        lat_q.push_back(cyc);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        a = 4'($urandom_range(0, 15));
        b = 4'($urandom_range(0, 15));
        c = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy && !done) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_reached", ok, 1);
    endtask

    task automatic run_hold(input logic signed [3:0] ai, input logic signed [3:0] bi,
                            input logic signed [3:0] ci);
        logic [17:0] e;
        e = model(ai, bi, ci);
        issue(ai, bi, ci);
        wait_idle();
        check("hold_status", status, e[17:16]);
        check("hold_x1", x1, $signed(e[15:8]));
        check("hold_x2", x2, $signed(e[7:0]));
    endtask

    initial begin
        logic seen;
        int   done_cnt;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; c = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_status", status, 0);
        check("rst_x1", x1, 0);
        check("rst_x2", x2, 0);
        check("rst_state", state_dbg, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        run_hold(4'sd1, -4'sd3, 4'sd2);
        run_hold(4'sd1, 4'sd1, -4'sd3);
        run_hold(-4'sd8, -4'sd8, 4'sd7);
        run_hold(4'sd1, 4'sd0, 4'sd1);
        run_hold(4'sd0, 4'sd3, 4'sd1);

        // start held high, pulsed mid-run, then chained from DONE
        a = -4'sd1; b = 4'sd2; c = 4'sd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        exp_q.push_back(model(-1, 2, 3));
        lat_q.push_back(cyc);
        a = 4'($urandom_range(0, 15));
        b = 4'($urandom_range(0, 15));
        c = 4'($urandom_range(0, 15));
        repeat (3) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("chain_done_seen", seen, 1);
        a = 4'sd1; b = 4'sd1; c = -4'sd3;
        @(posedge clk);
        @(negedge clk);
        exp_q.push_back(model(1, 1, -3));
        lat_q.push_back(cyc);
        start = 1'b0;
        check("chain_done_falls", done, 0);
        check("chain_busy", busy, 1);
        wait_idle();

        // Reset asserted at edge 8 of a run
        issue(4'sd1, -4'sd3, 4'sd2);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        exp_q.delete();
        lat_q.delete();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_status", status, 0);
        check("mid_rst_x1", x1, 0);
        check("mid_rst_x2", x2, 0);
        check("mid_rst_state", state_dbg, 0);
        rst = 1'b0;
        done_cnt = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("no_done_after_rst", done_cnt, 0);

        // Randomized runs
        for (int n = 0; n < 60; n++) begin
            issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)));
            wait_idle();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
